hyperbus_phy_traffic_gen: RTL
=============================

// Module: hyperbus_phy_traffic_gen
// PURPOSE
//  Synthesizable traffic generator / self-checker for hyperbus_phy.
//  Master side of the phy trans/tx/rx interfaces.
//  Runs looped write, read or write-then-read bursts with a deterministic data pattern, then compares read data.
//  Optional injection of rx_ready back-pressure.
//  Used for on-chip bring-up and as a reusable stimulus source in phy/RAM-model benches.
// PARAMETERS
//  NR_CS        2   chip-select width; matches the phy
//  BURST_WIDTH  12  burst-length width (16-bit words); matches the phy
//  LOOP_WIDTH   8   width of the loop counter
// PORTS
//  clk_i             in   1            system clock, same domain as phy clk_i
//  rst_ni            in   1            asynchronous active-low reset
//  start_i           in   1            start pulse; ignored while busy_o
//  mode_i            in   2            0=WRITE, 1=READ, 2/3=WRITE_READ
//  base_addr_i       in   32           first word address
//  burst_i           in   BURST_WIDTH  words per transaction
//  cs_i              in   NR_CS        one-hot chip select
//  seed_i            in   16           pattern seed
//  loops_i           in   LOOP_WIDTH   transactions (or W/R pairs) to run
//  stall_at_i        in   BURST_WIDTH  rx beat index at which back-pressure is injected
//  stall_len_i       in   8            back-pressure length in cycles; 0 = off
//  busy_o            out  1            run in progress
//  done_o            out  1            1-cycle pulse at end of run
//  err_cnt_o         out  16           mismatching read words (saturating)
//  first_err_addr_o  out  32           address of the first mismatch
//  trans_valid_o     out  1            phy trans_valid_i
//  trans_ready_i     in   1            phy trans_ready_o
//  trans_address_o   out  32
//  trans_cs_o        out  NR_CS
//  trans_write_o     out  1
//  trans_burst_o     out  BURST_WIDTH
//  tx_valid_o        out  1            phy tx_valid_i
//  tx_ready_i        in   1            phy tx_ready_o
//  tx_data_o         out  16
//  tx_strb_o         out  2            constant 2'b11 (both bytes written)
//  rx_valid_i        in   1            phy rx_valid_o
//  rx_ready_o        out  1            phy rx_ready_i
//  rx_data_i         in   16
// BEHAVIOUR
//  Reset: every output is 0 except tx_strb_o=2'b11. FSM goes to IDLE.
//  Start:
//   - Inputs are latched on start_i in IDLE.
//   - If burst_i==0 or loops_i==0: done_o pulses on the next cycle, no bus activity.
//   - Otherwise err_cnt_o and first_err_addr_o clear, busy_o rises on the next cycle, and trans_valid_o rises with it.
//  FSM: IDLE -> W_REQ -> W_DATA -> R_REQ -> R_DATA(<->STALL) -> NEXT -> ... -> DONE -> IDLE.
//   - WRITE mode skips R_*; READ mode skips W_*.
//  Loop n (0-based):
//   - addr = base + n*burst, modulo 2^32.
//   - Word i of loop n = seed + n + i, modulo 2^16.
//   - Expected address of word i = addr + i.
//  *_REQ states:
//   - trans_valid_o is held high with address/cs/write/burst stable until a cycle with trans_ready_i=1; it drops on the next cycle.
//   - trans_write_o is 1 in W_REQ and 0 in R_REQ.
//  W_DATA:
//   - tx_valid_o is high with word i held until tx_ready_i=1, then advances.
//   - After the last word is accepted: tx_valid_o=0, then go to R_REQ or NEXT.
//  R_DATA:
//   - rx_ready_o=1. A beat is taken when rx_valid_i && rx_ready_o.
//   - Each beat is compared to its expected word.
//   - On mismatch: err_cnt_o += 1 (saturates at 16'hFFFF). On the first mismatch of the run, first_err_addr_o <= addr+i.
//   - After burst beats: rx_ready_o=0, go to NEXT.
//  STALL:
//   - Entered once per read transaction, before taking beat stall_at_i, when stall_len_i!=0 and stall_at_i<burst.
//   - rx_ready_o=0 for exactly stall_len_i cycles, then back to R_DATA.
//   - stall_at_i=0 stalls before the first beat.
//  NEXT: n += 1. If n == loops: DONE, else the first REQ state of the loop.
//  DONE: done_o=1 for one cycle, busy_o=0. err_cnt_o and first_err_addr_o are held until the next accepted start.
//  rx beats arriving outside R_DATA are not consumed (rx_ready_o=0).
//  start_i while busy has no effect. Config changes after start have no effect.
//  Async reset mid-run: all valids and rx_ready_o drop immediately; the run is abandoned without a done_o pulse.
// TESTING (phy model or hyperbus_phy + s27ks0641 model)
//  1. WRITE_READ, addr 0, burst 8, seed 16'h1234, loops 1
//     -> writes 1234..123B, reads them back; err_cnt=0, one done pulse.
//  2. WRITE_READ, addr 32'h05FFF3, burst 16, stall_at 3, stall_len 8
//     -> rx_ready_o low for 8 cycles before beat 3; all 16 words match; err_cnt=0.
//  3. READ mode after a run with seed 0, now seed 1, burst 4
//     -> err_cnt=4; first_err_addr = base.
//  4. Loops 3, burst 4, base 32'hFFFF_FFFC
//     -> trans addresses FFFFFFFC, 0, 4; data seeds +0, +1, +2.
//  5. burst 0 -> done pulse one cycle after start, trans_valid_o never high.
//     trans_ready_i held low for 20 cycles -> trans_valid_o and fields stable throughout.
//  6. Assert rst_ni mid-W_DATA -> all outputs to reset values that cycle.
//     A new start then runs cleanly.

Source files
------------

// File: rtl/hyperbus_phy_traffic_gen.sv
// hyperbus_phy_traffic_gen: looped write/read burst generator and read-data checker for hyperbus_phy
module hyperbus_phy_traffic_gen #(
    parameter int NR_CS       = 2,
    parameter int BURST_WIDTH = 12,
    parameter int LOOP_WIDTH  = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   start_i,
    input  logic [1:0]             mode_i,
    input  logic [31:0]            base_addr_i,
    input  logic [BURST_WIDTH-1:0] burst_i,
    input  logic [NR_CS-1:0]       cs_i,
    input  logic [15:0]            seed_i,
    input  logic [LOOP_WIDTH-1:0]  loops_i,
    input  logic [BURST_WIDTH-1:0] stall_at_i,
    input  logic [7:0]             stall_len_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [15:0]            err_cnt_o,
    output logic [31:0]            first_err_addr_o,
    output logic                   trans_valid_o,
    input  logic                   trans_ready_i,
    output logic [31:0]            trans_address_o,
    output logic [NR_CS-1:0]       trans_cs_o,
    output logic                   trans_write_o,
    output logic [BURST_WIDTH-1:0] trans_burst_o,
    output logic                   tx_valid_o,
    input  logic                   tx_ready_i,
    output logic [15:0]            tx_data_o,
    output logic [1:0]             tx_strb_o,
    input  logic                   rx_valid_i,
    output logic                   rx_ready_o,
    input  logic [15:0]            rx_data_i
);
    typedef enum logic [2:0] {IDLE, W_REQ, W_DATA, R_REQ, R_DATA, STALL, NEXT, DONE} state_t;
    state_t state_q, state_d;
    logic [1:0] mode_q;
    logic [BURST_WIDTH-1:0] burst_q, stall_at_q, idx_q;
    logic [NR_CS-1:0] cs_q;
    logic [LOOP_WIDTH-1:0] loops_q, loop_q;
    logic [7:0] stall_len_q, stall_cnt_q;
    logic [31:0] addr_q, first_err_q;
    logic [15:0] pat_q, err_q;
    logic start_ok, zero_cfg, last_idx, stall_first, stall_next, mismatch;
    assign start_ok    = state_q == IDLE && start_i;
    assign zero_cfg    = burst_i == '0 || loops_i == '0;
    assign last_idx    = idx_q == burst_q - BURST_WIDTH'(1);
    assign stall_first = stall_len_q != 8'd0 && stall_at_q == '0;
    assign stall_next  = stall_len_q != 8'd0 && idx_q + BURST_WIDTH'(1) == stall_at_q;
    assign mismatch    = rx_data_i != pat_q + 16'(idx_q);
    // state register; reset abandons any run in progress
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else state_q <= state_d;
    end
    // next-state: stall is chosen on the edge that would otherwise present rx_ready for beat stall_at
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = zero_cfg ? DONE : (mode_i == 2'd1 ? R_REQ : W_REQ);
            W_REQ:   if (trans_ready_i) state_d = W_DATA;
            W_DATA:  if (tx_ready_i && last_idx) state_d = mode_q == 2'd0 ? NEXT : R_REQ;
            R_REQ:   if (trans_ready_i) state_d = stall_first ? STALL : R_DATA;
            R_DATA:  if (rx_valid_i) state_d = last_idx ? NEXT : (stall_next ? STALL : R_DATA);
            STALL:   if (stall_cnt_q == 8'd1) state_d = R_DATA;
            NEXT:    state_d = loop_q + LOOP_WIDTH'(1) == loops_q ? DONE : (mode_q == 2'd1 ? R_REQ : W_REQ);
            default: state_d = IDLE;
        endcase
    end
    // run configuration, loop/beat counters and read-data checking
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mode_q      <= '0;
            burst_q     <= '0;
            stall_at_q  <= '0;
            idx_q       <= '0;
            cs_q        <= '0;
            loops_q     <= '0;
            loop_q      <= '0;
            stall_len_q <= '0;
            stall_cnt_q <= '0;
            addr_q      <= '0;
            first_err_q <= '0;
            pat_q       <= '0;
            err_q       <= '0;
        end else begin
            if (start_ok) begin
                mode_q      <= mode_i;
                burst_q     <= burst_i;
                cs_q        <= cs_i;
                loops_q     <= loops_i;
                stall_at_q  <= stall_at_i;
                stall_len_q <= stall_len_i;
                addr_q      <= base_addr_i;
                pat_q       <= seed_i;
                loop_q      <= '0;
                if (!zero_cfg) begin
                    err_q       <= '0;
                    first_err_q <= '0;
                end
            end
            if (state_q == W_REQ || state_q == R_REQ) idx_q <= '0;
            else if ((state_q == W_DATA && tx_ready_i) || (state_q == R_DATA && rx_valid_i)) idx_q <= idx_q + BURST_WIDTH'(1);
            stall_cnt_q <= state_q == STALL ? stall_cnt_q - 8'd1 : stall_len_q;
            if (state_q == R_DATA && rx_valid_i && mismatch) begin
                if (err_q == '0) first_err_q <= addr_q + 32'(idx_q);
                if (err_q != 16'hFFFF) err_q <= err_q + 16'd1;
            end
            if (state_q == NEXT) begin
                loop_q <= loop_q + LOOP_WIDTH'(1);
                addr_q <= addr_q + 32'(burst_q);
                pat_q  <= pat_q + 16'd1;
            end
        end
    end
    assign busy_o           = state_q != IDLE && state_q != DONE;
    assign done_o           = state_q == DONE;
    assign err_cnt_o        = err_q;
    assign first_err_addr_o = first_err_q;
    assign trans_valid_o    = state_q == W_REQ || state_q == R_REQ;
    assign trans_address_o  = addr_q;
    assign trans_cs_o       = cs_q;
    assign trans_write_o    = state_q == W_REQ;
    assign trans_burst_o    = burst_q;
    assign tx_valid_o       = state_q == W_DATA;
    assign tx_data_o        = pat_q + 16'(idx_q);
    assign tx_strb_o        = 2'b11;
    assign rx_ready_o       = state_q == R_DATA;
endmodule
